// File: rtl/superscalar_pkg.sv
// Shared RV32I opcode constants and queue entry type for the dual-issue front end.
package superscalar_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } q_entry_t;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == LOAD) || (opc == STORE);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side push handshake, decode-side issue slots and status of the pair scheduler.
interface dual_issue_scheduler_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            fetch_valid;
  logic [XLEN-1:0] fetch_instr0;
  logic [XLEN-1:0] fetch_instr1;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            decode_stall;
  logic            flush;
  logic            issue_valid_0;
  logic [XLEN-1:0] issue_instr_0;
  logic [XLEN-1:0] issue_pc_0;
  logic            issue_valid_1;
  logic [XLEN-1:0] issue_instr_1;
  logic [XLEN-1:0] issue_pc_1;
  logic [CntW-1:0] q_count;
  logic [31:0]     split_cnt;

  modport master (
    output fetch_valid, fetch_instr0, fetch_instr1, fetch_pc, decode_stall, flush,
    input  fetch_ready, issue_valid_0, issue_instr_0, issue_pc_0,
    input  issue_valid_1, issue_instr_1, issue_pc_1, q_count, split_cnt
  );

  modport slave (
    input  fetch_valid, fetch_instr0, fetch_instr1, fetch_pc, decode_stall, flush,
    output fetch_ready, issue_valid_0, issue_instr_0, issue_pc_0,
    output issue_valid_1, issue_instr_1, issue_pc_1, q_count, split_cnt
  );

endinterface

// File: rtl/dual_issue_scheduler_pair_check.sv
// Decides whether two adjacent instructions may issue together (instr_a older, instr_b younger).
module pair_check #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] instr_a,
  input  logic [XLEN-1:0] instr_b,
  output logic            pair_ok
);
  import superscalar_pkg::*;

  logic [6:0] op_a, op_b;
  logic [4:0] rd_a, rs1_b, rs2_b;
  logic       a_writes, b_reads_rs1, b_reads_rs2, raw, mem_conflict, ctrl_a;
  logic       unused_bits;

  assign op_a  = instr_a[6:0];
  assign rd_a  = instr_a[11:7];
  assign op_b  = instr_b[6:0];
  assign rs1_b = instr_b[19:15];
  assign rs2_b = instr_b[24:20];

  assign unused_bits = ^{instr_a[XLEN-1:12], instr_b[XLEN-1:25], instr_b[14:7]};

  always_comb begin
    a_writes    = (op_a != STORE) && (op_a != BRANCH) && (rd_a != 5'd0);
    b_reads_rs1 = (op_b != LUI) && (op_b != AUIPC) && (op_b != JAL);
    // Unknown opcodes behave as OP, so rs2 is assumed read unless the format lacks it.
    b_reads_rs2 = !((op_b == LOAD) || (op_b == JAL) || (op_b == JALR) ||
                    (op_b == LUI) || (op_b == AUIPC) || (op_b == OP_IMM));
    raw = a_writes && ((b_reads_rs1 && (rs1_b == rd_a)) || (b_reads_rs2 && (rs2_b == rd_a)));
    mem_conflict = is_mem_op(op_a) && is_mem_op(op_b);
    ctrl_a       = (op_a == BRANCH) || (op_a == JAL) || (op_a == JALR);
    pair_ok      = !(raw || mem_conflict || ctrl_a);
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Instruction pair queue feeding two decode lanes; splits pairs that cannot issue together.
module dual_issue_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic                    clk,
  input logic                    reset,
  dual_issue_scheduler_if.slave  bus_io
);
  import superscalar_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  q_entry_t        mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     split_q, split_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [XLEN-1:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [XLEN-1:0] instr1_q, instr1_d, pc1_q, pc1_d;
  q_entry_t        head0_e, head1_e;
  logic            push, issue_en, has0, has1, pair_ok;
  logic [1:0]      pop;

  assign head1   = head_q + PtrW'(1);
  assign tail1   = tail_q + PtrW'(1);
  assign head0_e = mem_q[head_q];
  assign head1_e = mem_q[head1];

  pair_check #(
    .XLEN (XLEN)
  ) u_pair_check (
    .instr_a (head0_e.instr),
    .instr_b (head1_e.instr),
    .pair_ok (pair_ok)
  );

  assign bus_io.fetch_ready = !bus_io.flush && (count_q <= CntW'(DEPTH - 2));
  assign push     = bus_io.fetch_valid && bus_io.fetch_ready;
  assign issue_en = !bus_io.decode_stall && !bus_io.flush;
  assign has0     = (count_q != '0);
  assign has1     = (count_q >= CntW'(2)) && pair_ok;

  always_comb begin
    pop      = 2'd0;
    v0_d     = v0_q;
    v1_d     = v1_q;
    instr0_d = instr0_q;
    pc0_d    = pc0_q;
    instr1_d = instr1_q;
    pc1_d    = pc1_q;
    split_d  = split_q;
    if (bus_io.flush) begin
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      instr0_d = '0;
      pc0_d    = '0;
      instr1_d = '0;
      pc1_d    = '0;
    end else if (issue_en) begin
      pop      = {1'b0, has0} + {1'b0, has1};
      v0_d     = has0;
      v1_d     = has1;
      instr0_d = has0 ? head0_e.instr : '0;
      pc0_d    = has0 ? head0_e.pc    : '0;
      instr1_d = has1 ? head1_e.instr : '0;
      pc1_d    = has1 ? head1_e.pc    : '0;
      if ((count_q >= CntW'(2)) && !pair_ok && (split_q != '1)) begin
        split_d = split_q + 32'd1;
      end
    end
    head_d  = bus_io.flush ? '0 : head_q + PtrW'(pop);
    tail_d  = bus_io.flush ? '0 : (push ? tail_q + PtrW'(2) : tail_q);
    count_d = bus_io.flush ? '0 : count_q + (push ? CntW'(2) : '0) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      split_q  <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      instr0_q <= '0;
      pc0_q    <= '0;
      instr1_q <= '0;
      pc1_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      split_q  <= split_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      instr0_q <= instr0_d;
      pc0_q    <= pc0_d;
      instr1_q <= instr1_d;
      pc1_q    <= pc1_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[tail_q] <= '{instr: bus_io.fetch_instr0, pc: bus_io.fetch_pc};
      mem_q[tail1]  <= '{instr: bus_io.fetch_instr1, pc: bus_io.fetch_pc + XLEN'(4)};
    end
  end

  assign bus_io.issue_valid_0 = v0_q;
  assign bus_io.issue_instr_0 = instr0_q;
  assign bus_io.issue_pc_0    = pc0_q;
  assign bus_io.issue_valid_1 = v1_q;
  assign bus_io.issue_instr_1 = instr1_q;
  assign bus_io.issue_pc_1    = pc1_q;
  assign bus_io.q_count       = count_q;
  assign bus_io.split_cnt     = split_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: expected issues queued at push, checked on issue.
module tb_dual_issue_scheduler;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          lane;
  } exp_t;

  exp_t exp_q[$];

  dual_issue_scheduler_if #(.DEPTH(4), .XLEN(32)) bus ();

  dual_issue_scheduler #(
    .DEPTH (4),
    .XLEN  (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  // beq rs1, rs2, +8
  function automatic logic [31:0] beq8(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 4'b0100, 1'b0, 7'b1100011};
  endfunction

  task automatic expect_issue(input logic [31:0] instr, input logic [31:0] pc, input int lane);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.lane  = lane;
    exp_q.push_back(e);
  endtask

  // One clock; any newly issued slot is popped from the scoreboard in program order.
  task automatic tick();
    logic        en;
    logic        v;
    logic [31:0] ins, pc;
    exp_t        e;
    en = !bus.decode_stall && !bus.flush && !reset;
    @(posedge clk);
    #1;
    if (en) begin
      for (int l = 0; l < 2; l++) begin
        v   = (l == 0) ? bus.issue_valid_0 : bus.issue_valid_1;
        ins = (l == 0) ? bus.issue_instr_0 : bus.issue_instr_1;
        pc  = (l == 0) ? bus.issue_pc_0    : bus.issue_pc_1;
        if (v) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue lane%0d: got instr %h pc %h, required nothing",
                     l, ins, pc);
          end else begin
            e = exp_q.pop_front();
            if (ins !== e.instr || pc !== e.pc || l != e.lane) begin
              n_fail++;
              $display("FAIL issue_order: got lane%0d instr %h pc %h, required lane%0d instr %h pc %h",
                       l, ins, pc, e.lane, e.instr, e.pc);
            end
          end
        end
      end
    end
  endtask

  task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    bus.fetch_valid  = 1'b1;
    bus.fetch_instr0 = i0;
    bus.fetch_instr1 = i1;
    bus.fetch_pc     = pc;
    tick();
    bus.fetch_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.q_count !== 3'd0 || bus.split_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got q_count %0d split %0d, required 0 0", bus.q_count, bus.split_cnt);
    end
    n_checks++;
    if (bus.issue_valid_0 !== 1'b0 || bus.issue_valid_1 !== 1'b0 ||
        bus.issue_instr_0 !== 32'd0 || bus.issue_pc_1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_issue: got v0 %b v1 %b i0 %h pc1 %h, required all 0",
               bus.issue_valid_0, bus.issue_valid_1, bus.issue_instr_0, bus.issue_pc_1);
    end
    n_checks++;
    if (bus.fetch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", bus.fetch_ready);
    end
  endtask

  task automatic test_independent();
    expect_issue(addi(5'd1, 5'd0, 12'd1), 32'h100, 0);
    expect_issue(addi(5'd2, 5'd0, 12'd2), 32'h104, 1);
    push_pair(addi(5'd1, 5'd0, 12'd1), addi(5'd2, 5'd0, 12'd2), 32'h100);
    n_checks++;
    if (bus.q_count !== 3'd2) begin
      n_fail++;
      $display("FAIL indep_push_count: got %0d, required 2", bus.q_count);
    end
    tick();
    n_checks++;
    if (bus.q_count !== 3'd0 || exp_q.size() != 0 || bus.split_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL indep_issue: got q_count %0d pending %0d split %0d, required 0 0 0",
               bus.q_count, exp_q.size(), bus.split_cnt);
    end
  endtask

  task automatic test_raw_split();
    expect_issue(addi(5'd5, 5'd0, 12'd1), 32'h200, 0);
    expect_issue(add(5'd6, 5'd5, 5'd5), 32'h204, 0);
    push_pair(addi(5'd5, 5'd0, 12'd1), add(5'd6, 5'd5, 5'd5), 32'h200);
    tick();
    n_checks++;
    if (bus.issue_valid_0 !== 1'b1 || bus.issue_valid_1 !== 1'b0 || bus.q_count !== 3'd1) begin
      n_fail++;
      $display("FAIL raw_first: got v0 %b v1 %b q %0d, required 1 0 1",
               bus.issue_valid_0, bus.issue_valid_1, bus.q_count);
    end
    tick();
    n_checks++;
    if (bus.split_cnt !== 32'd1 || exp_q.size() != 0 || bus.issue_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_second: got split %0d pending %0d v1 %b, required 1 0 0",
               bus.split_cnt, exp_q.size(), bus.issue_valid_1);
    end
  endtask

  task automatic test_mem_conflict();
    expect_issue(lw(5'd1, 5'd2, 12'd0), 32'h300, 0);
    expect_issue(sw(5'd3, 5'd4, 12'd4), 32'h304, 0);
    push_pair(lw(5'd1, 5'd2, 12'd0), sw(5'd3, 5'd4, 12'd4), 32'h300);
    tick();
    tick();
    n_checks++;
    if (bus.split_cnt !== 32'd2 || exp_q.size() != 0 || bus.q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mem_conflict: got split %0d pending %0d q %0d, required 2 0 0",
               bus.split_cnt, exp_q.size(), bus.q_count);
    end
  endtask

  task automatic test_full_wrap();
    bus.decode_stall = 1'b1;
    expect_issue(addi(5'd1, 5'd0, 12'd1), 32'h400, 0);
    expect_issue(addi(5'd2, 5'd0, 12'd2), 32'h404, 1);
    expect_issue(addi(5'd3, 5'd0, 12'd3), 32'h408, 0);
    expect_issue(addi(5'd4, 5'd0, 12'd4), 32'h40c, 1);
    expect_issue(addi(5'd7, 5'd0, 12'd7), 32'h410, 0);
    expect_issue(addi(5'd8, 5'd0, 12'd8), 32'h414, 1);
    push_pair(addi(5'd1, 5'd0, 12'd1), addi(5'd2, 5'd0, 12'd2), 32'h400);
    push_pair(addi(5'd3, 5'd0, 12'd3), addi(5'd4, 5'd0, 12'd4), 32'h408);
    n_checks++;
    if (bus.q_count !== 3'd4 || bus.fetch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full: got q %0d ready %b, required 4 0", bus.q_count, bus.fetch_ready);
    end
    bus.decode_stall = 1'b0;
    tick();
    n_checks++;
    if (bus.q_count !== 3'd2 || bus.fetch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_half: got q %0d ready %b, required 2 1", bus.q_count, bus.fetch_ready);
    end
    push_pair(addi(5'd7, 5'd0, 12'd7), addi(5'd8, 5'd0, 12'd8), 32'h410);
    n_checks++;
    if (bus.q_count !== 3'd2) begin
      n_fail++;
      $display("FAIL push_pop_same_edge: got q %0d, required 2", bus.q_count);
    end
    tick();
    n_checks++;
    if (bus.q_count !== 3'd0 || exp_q.size() != 0 || bus.split_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_done: got q %0d pending %0d split %0d, required 0 0 2",
               bus.q_count, exp_q.size(), bus.split_cnt);
    end
  endtask

  task automatic test_flush();
    expect_issue(addi(5'd5, 5'd0, 12'd1), 32'h500, 0);
    push_pair(addi(5'd5, 5'd0, 12'd1), add(5'd6, 5'd5, 5'd5), 32'h500);
    push_pair(addi(5'd9, 5'd0, 12'd1), addi(5'd10, 5'd0, 12'd2), 32'h508);
    n_checks++;
    if (bus.q_count !== 3'd3 || bus.issue_valid_0 !== 1'b1 || bus.issue_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_flush: got q %0d v0 %b v1 %b, required 3 1 0",
               bus.q_count, bus.issue_valid_0, bus.issue_valid_1);
    end
    bus.flush        = 1'b1;
    bus.fetch_valid  = 1'b1;
    bus.fetch_instr0 = addi(5'd11, 5'd0, 12'd3);
    bus.fetch_instr1 = addi(5'd12, 5'd0, 12'd4);
    bus.fetch_pc     = 32'h600;
    #1;
    n_checks++;
    if (bus.fetch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b, required 0", bus.fetch_ready);
    end
    tick();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    n_checks++;
    if (bus.q_count !== 3'd0 || bus.issue_valid_0 !== 1'b0 || bus.issue_valid_1 !== 1'b0 ||
        bus.split_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL flush: got q %0d v0 %b v1 %b split %0d, required 0 0 0 3",
               bus.q_count, bus.issue_valid_0, bus.issue_valid_1, bus.split_cnt);
    end
    tick();
    tick();
    n_checks++;
    if (bus.q_count !== 3'd0 || bus.issue_valid_0 !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drop: got q %0d v0 %b pending %0d, required 0 0 0",
               bus.q_count, bus.issue_valid_0, exp_q.size());
    end
  endtask

  task automatic test_control();
    expect_issue(beq8(5'd1, 5'd2), 32'h700, 0);
    expect_issue(addi(5'd3, 5'd0, 12'd1), 32'h704, 0);
    push_pair(beq8(5'd1, 5'd2), addi(5'd3, 5'd0, 12'd1), 32'h700);
    tick();
    n_checks++;
    if (bus.issue_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_alone: got v1 %b, required 0", bus.issue_valid_1);
    end
    tick();
    n_checks++;
    if (bus.split_cnt !== 32'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ctrl_split: got split %0d pending %0d, required 4 0",
               bus.split_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.decode_stall = 1'b1;
    push_pair(addi(5'd1, 5'd0, 12'd5), addi(5'd2, 5'd0, 12'd6), 32'h800);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.decode_stall = 1'b0;
    n_checks++;
    if (bus.q_count !== 3'd0 || bus.split_cnt !== 32'd0 || bus.issue_valid_0 !== 1'b0 ||
        bus.fetch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got q %0d split %0d v0 %b ready %b, required 0 0 0 1",
               bus.q_count, bus.split_cnt, bus.issue_valid_0, bus.fetch_ready);
    end
    tick();
    n_checks++;
    if (bus.issue_valid_0 !== 1'b0 || bus.q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_empty: got v0 %b q %0d, required 0 0",
               bus.issue_valid_0, bus.q_count);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.fetch_valid  = 1'b0;
    bus.fetch_instr0 = '0;
    bus.fetch_instr1 = '0;
    bus.fetch_pc     = '0;
    bus.decode_stall = 1'b0;
    bus.flush        = 1'b0;
    test_reset();
    test_independent();
    test_raw_split();
    test_mem_conflict();
    test_full_wrap();
    test_flush();
    test_control();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
